// File: rtl/readout_accum.sv
`default_nettype none
// ============================================================================
// Module      : readout_accum
// Description : Two-lane (I/Q) readout accumulator. Sums decoded +1/0/-1 codes
//               over a power-of-two window with saturation and offers each
//               window sum as a frame over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module readout_accum (
    input  logic        clk_master,
    input  logic        rstb,
    input  logic        ud_en,
    input  logic        sample_stb,
    input  logic [1:0]  read_out_I,
    input  logic [1:0]  read_out_Q,
    input  logic [2:0]  win_sel,
    input  logic        clr,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [11:0] frame_I,
    output logic [11:0] frame_Q,
    output logic [3:0]  frame_seq,
    output logic        overrun,
    output logic        busy
);

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_accum = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic signed [11:0] r_acc_i;
    logic signed [11:0] r_acc_q;
    logic signed [11:0] w_base_i;
    logic signed [11:0] w_base_q;
    logic [10:0]        r_cnt;
    logic [10:0]        w_last_idx;
    logic [2:0]         r_win_sel;
    logic               r_win_end;
    logic               w_win_done;
    logic [3:0]         r_seq_next;
    logic               w_xfer;
    logic               w_load;
    logic               w_drop;

    function automatic logic signed [11:0] sat_add(input logic signed [11:0] a,
                                                   input logic [1:0]         code);
        logic signed [12:0] d;
        logic signed [12:0] s;
        d = (code == 2'b01) ? 13'sd1 : ((code == 2'b11) ? -13'sd1 : 13'sd0);
        s = {a[11], a} + d;
        if (s > 13'sd2047)
            sat_add = 12'h7FF;
        else if (s < -13'sd2048)
            sat_add = 12'h800;
        else
            sat_add = s[11:0];
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb)
            r_state <= c_st_idle;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (ud_en)  w_state_nxt = c_st_accum;
            c_st_accum: if (!ud_en) w_state_nxt = c_st_idle;
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        busy = (r_state == c_st_accum);
    end

    // ----------------------------------------------------------- datapath
    // Last sample index N-1 is a mask of (win_sel+4) ones.
    assign w_last_idx = ~(11'h7F0 << r_win_sel);
    assign w_win_done = (r_state == c_st_accum) && ud_en && sample_stb &&
                        (r_cnt == w_last_idx);

    // The finished sum is held one cycle for the frame register, so the new
    // window starts from zero on the following edge.
    assign w_base_i = r_win_end ? 12'sd0 : r_acc_i;
    assign w_base_q = r_win_end ? 12'sd0 : r_acc_q;

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            r_acc_i   <= '0;
            r_acc_q   <= '0;
            r_cnt     <= '0;
            r_win_sel <= '0;
            r_win_end <= 1'b0;
        end else begin
            r_win_end <= w_win_done;
            if (r_state == c_st_idle || !ud_en) begin
                r_acc_i <= '0;
                r_acc_q <= '0;
                r_cnt   <= '0;
                if (r_state == c_st_idle && ud_en)
                    r_win_sel <= win_sel;
            end else begin
                if (r_win_end)
                    r_win_sel <= win_sel;
                if (sample_stb) begin
                    r_acc_i <= sat_add(w_base_i, read_out_I);
                    r_acc_q <= sat_add(w_base_q, read_out_Q);
                    r_cnt   <= w_win_done ? 11'd0 : r_cnt + 11'd1;
                end else begin
                    r_acc_i <= w_base_i;
                    r_acc_q <= w_base_q;
                end
            end
        end
    end

    // ------------------------------------------------------ frame output
    assign w_xfer = frame_valid & frame_ready;
    assign w_load = r_win_end & (~frame_valid | w_xfer);
    assign w_drop = r_win_end & frame_valid & ~frame_ready;

    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            frame_valid <= 1'b0;
            frame_I     <= '0;
            frame_Q     <= '0;
            frame_seq   <= '0;
            r_seq_next  <= '0;
            overrun     <= 1'b0;
        end else begin
            if (w_load) begin
                frame_valid <= 1'b1;
                frame_I     <= r_acc_i;
                frame_Q     <= r_acc_q;
                frame_seq   <= r_seq_next;
            end else if (w_xfer) begin
                frame_valid <= 1'b0;
            end

            if (clr)
                r_seq_next <= '0;
            else if (w_load)
                r_seq_next <= r_seq_next + 4'd1;

            // A drop on the same edge as clr leaves the flag set.
            if (w_drop)
                overrun <= 1'b1;
            else if (clr)
                overrun <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_readout_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_readout_accum
// Description : Self-checking bench for readout_accum with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_readout_accum;

    logic        clk_master  = 1'b0;
    logic        rstb        = 1'b0;
    logic        ud_en       = 1'b0;
    logic        sample_stb  = 1'b0;
    logic [1:0]  read_out_I  = 2'b00;
    logic [1:0]  read_out_Q  = 2'b00;
    logic [2:0]  win_sel     = 3'd0;
    logic        clr         = 1'b0;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [11:0] frame_I;
    logic [11:0] frame_Q;
    logic [3:0]  frame_seq;
    logic        overrun;
    logic        busy;
    logic [30:0] dut_vec;

    int n_cmp  = 0;
    int n_fail = 0;

    readout_accum u_dut (
        .clk_master  (clk_master),
        .rstb        (rstb),
        .ud_en       (ud_en),
        .sample_stb  (sample_stb),
        .read_out_I  (read_out_I),
        .read_out_Q  (read_out_Q),
        .win_sel     (win_sel),
        .clr         (clr),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .frame_I     (frame_I),
        .frame_Q     (frame_Q),
        .frame_seq   (frame_seq),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk_master = ~clk_master;

    assign dut_vec = {frame_valid, frame_I, frame_Q, frame_seq, overrun, busy};

    // ------------------------------------------------ behavioural model
    bit m_accum, m_pend, m_valid, m_ovr;
    int m_sum_i, m_sum_q, m_cnt, m_len;
    int m_pend_i, m_pend_q, m_fi, m_fq, m_fseq, m_seq_next;

    function automatic int code_val(input logic [1:0] c);
        if (c == 2'b01) return 1;
        if (c == 2'b11) return -1;
        return 0;
    endfunction

    function automatic int clamp(input int v);
        if (v > 2047)  return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic logic [30:0] exp_vec();
        return {m_valid, 12'(m_fi), 12'(m_fq), 4'(m_fseq), m_ovr, m_accum};
    endfunction

    task automatic model_reset();
        m_accum = 0; m_pend = 0; m_valid = 0; m_ovr = 0;
        m_sum_i = 0; m_sum_q = 0; m_cnt = 0; m_len = 16;
        m_pend_i = 0; m_pend_q = 0; m_fi = 0; m_fq = 0; m_fseq = 0; m_seq_next = 0;
    endtask

    // Advances the model by one rising edge using the current input values.
    task automatic model_edge();
        bit xfer, drop, done;
        xfer = m_valid && frame_ready;
        drop = m_pend && m_valid && !frame_ready;
        if (m_pend && !drop) begin
            m_valid    = 1;
            m_fi       = m_pend_i;
            m_fq       = m_pend_q;
            m_fseq     = m_seq_next;
            m_seq_next = (m_seq_next + 1) % 16;
        end else if (xfer) begin
            m_valid = 0;
        end
        if (drop) m_ovr = 1;
        else if (clr) m_ovr = 0;
        if (clr) m_seq_next = 0;

        done = 0;
        if (!m_accum) begin
            if (ud_en) begin
                m_accum = 1; m_sum_i = 0; m_sum_q = 0; m_cnt = 0;
                m_len = 16 << win_sel;
            end
        end else if (!ud_en) begin
            m_accum = 0; m_sum_i = 0; m_sum_q = 0; m_cnt = 0;
        end else begin
            if (m_pend) m_len = 16 << win_sel;
            if (sample_stb) begin
                m_sum_i = clamp(m_sum_i + code_val(read_out_I));
                m_sum_q = clamp(m_sum_q + code_val(read_out_Q));
                m_cnt++;
                if (m_cnt == m_len) begin
                    done = 1;
                    m_pend_i = m_sum_i; m_pend_q = m_sum_q;
                    m_sum_i = 0; m_sum_q = 0; m_cnt = 0;
                end
            end
        end
        m_pend = done;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk_master);
        #1;
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        model_reset();
        rstb = 1'b0;
        repeat (2) @(posedge clk_master);
        #1;
        n_cmp++;
        if (dut_vec !== 31'h0) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", dut_vec, 31'h0);
        end
        @(negedge clk_master);
        rstb = 1'b1;
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL reset_idle: got %h expected %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_basic();
        win_sel = 3'd0; frame_ready = 1'b1; ud_en = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_entry_busy: got %b expected 1", busy);
        end
        for (int i = 0; i < 16; i++) begin
            sample_stb = 1'b1; read_out_I = 2'b01; read_out_Q = 2'b11;
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL basic_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        n_cmp++;
        if (frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_latency_early: got %b expected 0", frame_valid);
        end
        sample_stb = 1'b0;
        tick();
        n_cmp++;
        if ({frame_valid, frame_I, frame_Q, frame_seq} !== {1'b1, 12'h010, 12'hFF0, 4'd0}) begin
            n_fail++; $display("FAIL basic_frame: got v=%b I=%h Q=%h seq=%0d expected v=1 I=010 Q=ff0 seq=0",
                               frame_valid, frame_I, frame_Q, frame_seq);
        end
        tick();
        n_cmp++;
        if (frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_one_cycle: got %b expected 0", frame_valid);
        end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 10; i++) begin
            sample_stb = 1'b1; read_out_I = 2'b01; read_out_Q = 2'b01;
            tick();
        end
        sample_stb = 1'b0; ud_en = 1'b0;
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec() || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: got %h expected %h", dut_vec, exp_vec());
        end
        ud_en = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            sample_stb = 1'b1; read_out_I = 2'b11; read_out_Q = 2'b00;
            tick();
            n_cmp++;
            if (frame_valid !== 1'b0) begin
                n_fail++; $display("FAIL abort_no_partial%0d: got %b expected 0", i, frame_valid);
            end
        end
        sample_stb = 1'b0;
        tick();
        n_cmp++;
        if ({frame_valid, frame_I, frame_Q, frame_seq} !== {1'b1, 12'hFF0, 12'h000, 4'd1}) begin
            n_fail++; $display("FAIL abort_frame: got v=%b I=%h Q=%h seq=%0d expected v=1 I=ff0 Q=000 seq=1",
                               frame_valid, frame_I, frame_Q, frame_seq);
        end
    endtask

    task automatic test_saturate();
        ud_en = 1'b0;
        tick();
        win_sel = 3'd7; ud_en = 1'b1;
        tick();
        win_sel = 3'd0;
        for (int i = 0; i < 2048; i++) begin
            sample_stb = 1'b1; read_out_I = 2'b01; read_out_Q = 2'b00;
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL sat_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        sample_stb = 1'b0;
        tick();
        n_cmp++;
        if ({frame_valid, frame_I, frame_Q} !== {1'b1, 12'h7FF, 12'h000}) begin
            n_fail++; $display("FAIL sat_frame: got v=%b I=%h Q=%h expected v=1 I=7ff Q=000",
                               frame_valid, frame_I, frame_Q);
        end
    endtask

    task automatic test_overrun();
        clr = 1'b1;
        tick();
        clr = 1'b0; frame_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            sample_stb = 1'b1;
            read_out_I = (i < 16) ? 2'b01 : 2'b11;
            read_out_Q = (i < 16) ? 2'b00 : 2'b11;
            tick();
        end
        sample_stb = 1'b0;
        tick();
        n_cmp++;
        if ({frame_valid, frame_I, frame_seq, overrun} !== {1'b1, 12'h010, 4'd0, 1'b1}) begin
            n_fail++; $display("FAIL ovr_drop: got v=%b I=%h seq=%0d ovr=%b expected v=1 I=010 seq=0 ovr=1",
                               frame_valid, frame_I, frame_seq, overrun);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if ({frame_valid, overrun} !== 2'b10) begin
            n_fail++; $display("FAIL ovr_clr: got v=%b ovr=%b expected v=1 ovr=0", frame_valid, overrun);
        end
    endtask

    task automatic test_back_to_back();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            sample_stb = 1'b1;
            read_out_I = (i < 16) ? 2'b01 : 2'b11;
            read_out_Q = 2'b01;
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL b2b_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        frame_ready = 1'b1; sample_stb = 1'b0;
        tick();
        n_cmp++;
        if ({frame_valid, frame_I, frame_Q, frame_seq, overrun} !== {1'b1, 12'hFF0, 12'h010, 4'd1, 1'b0}) begin
            n_fail++; $display("FAIL b2b_frame: got v=%b I=%h Q=%h seq=%0d ovr=%b expected v=1 I=ff0 Q=010 seq=1 ovr=0",
                               frame_valid, frame_I, frame_Q, frame_seq, overrun);
        end
        tick();
        n_cmp++;
        if (frame_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: got %b expected 0", frame_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            ud_en       = ($urandom_range(0, 63) != 0);
            sample_stb  = $urandom_range(0, 1) == 1;
            read_out_I  = 2'($urandom_range(0, 3));
            read_out_Q  = 2'($urandom_range(0, 3));
            win_sel     = 3'($urandom_range(0, 2));
            frame_ready = ($urandom_range(0, 3) != 0);
            clr         = ($urandom_range(0, 63) == 0);
            tick();
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("FAIL rand_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_async_reset();
        bit reached;
        sample_stb = 1'b0; win_sel = 3'd0; frame_ready = 1'b1; ud_en = 1'b0;
        repeat (2) tick();
        frame_ready = 1'b0; ud_en = 1'b1;
        tick();
        reached = 0;
        for (int i = 0; i < 200 && !reached; i++) begin
            sample_stb = 1'b1; read_out_I = 2'b01; read_out_Q = 2'b11;
            tick();
            reached = m_valid && (m_cnt >= 4);
        end
        n_cmp++;
        if (!reached || frame_valid !== 1'b1) begin
            n_fail++; $display("FAIL arst_setup: got v=%b expected v=1 mid-window", frame_valid);
        end
        #3;
        rstb = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec !== 31'h0) begin
            n_fail++; $display("FAIL arst_immediate: got %h expected %h", dut_vec, 31'h0);
        end
        #2;
        rstb = 1'b1;
        frame_ready = 1'b1; sample_stb = 1'b0;
        tick();
        n_cmp++;
        if (dut_vec !== exp_vec()) begin
            n_fail++; $display("FAIL arst_reentry: got %h expected %h", dut_vec, exp_vec());
        end
        for (int i = 0; i < 16; i++) begin
            sample_stb = 1'b1;
            read_out_I = (i % 2 == 0) ? 2'b00 : 2'b10;
            read_out_Q = (i % 2 == 0) ? 2'b10 : 2'b00;
            tick();
        end
        sample_stb = 1'b0;
        tick();
        n_cmp++;
        if ({frame_valid, frame_I, frame_Q, frame_seq} !== {1'b1, 12'h000, 12'h000, 4'd0}) begin
            n_fail++; $display("FAIL zero_codes: got v=%b I=%h Q=%h seq=%0d expected v=1 I=000 Q=000 seq=0",
                               frame_valid, frame_I, frame_Q, frame_seq);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_abort();
        test_saturate();
        test_overrun();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
